// File: rtl/wb_arb_sched.sv
// rtl/wb_arb_sched.sv - Wishbone bus arbiter: fixed-priority or round-robin grant with a bounded hold time
// The grant parks on its last owner while idle; a parked owner re-arbitrates like any other requester.
module wb_arb_sched #(
  parameter int NM      = 8,
  parameter int GNTW    = $clog2(NM),
  parameter int MAXHOLD = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NM-1:0]   req_i,
  input  logic            mode_i,
  output logic [GNTW-1:0] gnt_o,
  output logic [NM-1:0]   gnt_oh_o,
  output logic            gnt_vld_o,
  output logic            preempt_o
);

  localparam logic [7:0] HOLD_MAX = (MAXHOLD > 0) ? 8'(MAXHOLD - 1) : 8'd0;

  logic [GNTW-1:0] r_gnt, w_gnt_nxt, w_pick;
  logic [7:0]      r_hold, w_hold_nxt;
  logic            r_active, w_active_nxt;
  logic            r_preempt, w_preempt_nxt;
  logic [NM-1:0]   w_oh, w_cand;
  logic            w_owner_req, w_others, w_limit, w_timeout, w_found;

  always_comb begin
    w_oh        = '0;
    w_oh[r_gnt] = 1'b1;
  end

  assign w_owner_req = req_i[r_gnt];
  assign w_others    = |(req_i & ~w_oh);
  assign w_limit     = (MAXHOLD > 0) && (r_hold == HOLD_MAX);
  // r_active is low while parked, so a returning owner does not inherit the bus for free
  assign w_timeout   = r_active && w_owner_req && w_limit && w_others;
  assign w_cand      = w_timeout ? (req_i & ~w_oh) : req_i;

  always_comb begin
    int idx;
    idx     = 0;
    w_pick  = r_gnt;
    w_found = 1'b0;
    if (!mode_i) begin
      for (int i = NM - 1; i >= 0; i--) begin
        if (w_cand[GNTW'(i)]) begin
          w_pick  = GNTW'(i);
          w_found = 1'b1;
        end
      end
    end else begin
      // i == NM revisits the owner last, which only matters for a parked owner
      for (int i = 1; i <= NM; i++) begin
        idx = int'(r_gnt) + i;
        if (idx >= NM) idx = idx - NM;
        if (!w_found && w_cand[GNTW'(idx)]) begin
          w_pick  = GNTW'(idx);
          w_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_gnt_nxt     = r_gnt;
    w_active_nxt  = r_active;
    w_preempt_nxt = 1'b0;
    w_hold_nxt    = r_hold;
    if (w_owner_req && r_active && !w_timeout) begin
      w_active_nxt = 1'b1;
    end else if (w_found) begin
      w_gnt_nxt     = w_pick;
      w_active_nxt  = 1'b1;
      w_preempt_nxt = w_timeout;
    end else begin
      w_active_nxt = 1'b0;
    end
    if ((w_gnt_nxt != r_gnt) || !w_owner_req) begin
      w_hold_nxt = 8'd0;
    end else if ((MAXHOLD > 0) && (r_hold != HOLD_MAX)) begin
      w_hold_nxt = r_hold + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gnt     <= '0;
      r_hold    <= 8'd0;
      r_active  <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_hold    <= w_hold_nxt;
      r_active  <= w_active_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  assign gnt_o     = r_gnt;
  assign gnt_oh_o  = w_oh;
  assign gnt_vld_o = w_owner_req;
  assign preempt_o = r_preempt;

endmodule

// File: tb/tb_wb_arb_sched.sv
// tb/tb_wb_arb_sched.sv - directed bench for wb_arb_sched (NM=8 unlimited, NM=8 MAXHOLD=4, NM=5)
module tb_wb_arb_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;

  logic       rst_a, mode_a, vld_a, pre_a;
  logic [7:0] req_a, oh_a;
  logic [2:0] gnt_a;
  logic       rst_b, mode_b, vld_b, pre_b;
  logic [7:0] req_b, oh_b;
  logic [2:0] gnt_b;
  logic       rst_c, mode_c, vld_c, pre_c;
  logic [4:0] req_c, oh_c;
  logic [2:0] gnt_c;

  wb_arb_sched #(.NM(8), .MAXHOLD(0)) u_arb8 (
    .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .mode_i(mode_a),
    .gnt_o(gnt_a), .gnt_oh_o(oh_a), .gnt_vld_o(vld_a), .preempt_o(pre_a)
  );

  wb_arb_sched #(.NM(8), .MAXHOLD(4)) u_arb8_hold (
    .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .mode_i(mode_b),
    .gnt_o(gnt_b), .gnt_oh_o(oh_b), .gnt_vld_o(vld_b), .preempt_o(pre_b)
  );

  wb_arb_sched #(.NM(5), .MAXHOLD(0)) u_arb5 (
    .clk_i(clk), .rst_i(rst_c), .req_i(req_c), .mode_i(mode_c),
    .gnt_o(gnt_c), .gnt_oh_o(oh_c), .gnt_vld_o(vld_c), .preempt_o(pre_c)
  );

  // Decode and range of the grant are checked on every falling edge once out of the first reset
  always @(negedge clk) begin
    if (mon_en) begin
      n_vec++;
      if (gnt_c > 3'd4 || oh_c !== (5'd1 << gnt_c)) begin
        n_err++;
        $display("FAIL onehot_nm5 gnt=%0d oh=%b want gnt<=4 and oh=%b", gnt_c, oh_c, 5'd1 << gnt_c);
      end
      n_vec++;
      if (oh_a !== (8'd1 << gnt_a)) begin
        n_err++;
        $display("FAIL onehot_nm8 gnt=%0d oh=%b want %b", gnt_a, oh_a, 8'd1 << gnt_a);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    req_a = 8'hFF; req_b = 8'h40; req_c = 5'h1F;
    mode_a = 1'b1; mode_b = 1'b1; mode_c = 1'b1;
    tick();
    n_vec++; if (gnt_a !== 3'd0) begin n_err++; $display("FAIL reset_gnt_a got %0d want 0", gnt_a); end
    n_vec++; if (oh_a !== 8'h01) begin n_err++; $display("FAIL reset_oh_a got %h want 01", oh_a); end
    n_vec++; if (pre_a !== 1'b0) begin n_err++; $display("FAIL reset_pre_a got %b want 0", pre_a); end
    n_vec++; if (gnt_b !== 3'd0) begin n_err++; $display("FAIL reset_gnt_b got %0d want 0", gnt_b); end
    n_vec++; if (oh_c !== 5'h01) begin n_err++; $display("FAIL reset_oh_c got %h want 01", oh_c); end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    req_a = 8'h00; req_b = 8'h00; req_c = 5'h00;
    tick();
    mon_en = 1'b1;
    n_vec++; if (gnt_a !== 3'd0) begin n_err++; $display("FAIL idle_park_gnt got %0d want 0", gnt_a); end
    n_vec++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL idle_park_vld got %b want 0", vld_a); end
  endtask

  task automatic test_fixed_priority;
    logic [7:0] t_req [8] = '{8'h0C, 8'h0D, 8'h0D, 8'h08, 8'h00, 8'h09, 8'h00, 8'h01};
    logic [2:0] t_gnt [8] = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0};
    logic       t_vld [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    mode_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      req_a = t_req[k];
      tick();
      n_vec++;
      if (gnt_a !== t_gnt[k] || vld_a !== t_vld[k]) begin
        n_err++;
        $display("FAIL fixed[%0d] req=%h gnt=%0d vld=%b want gnt=%0d vld=%b",
                 k, t_req[k], gnt_a, vld_a, t_gnt[k], t_vld[k]);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] t_req  [9] = '{8'h20, 8'h61, 8'h41, 8'h01, 8'h81, 8'h86, 8'h84, 8'h80, 8'h03};
    logic       t_mode [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] t_gnt  [9] = '{3'd5, 3'd5, 3'd6, 3'd0, 3'd0, 3'd1, 3'd2, 3'd7, 3'd0};
    for (int k = 0; k < 9; k++) begin
      req_a  = t_req[k];
      mode_a = t_mode[k];
      tick();
      n_vec++;
      if (gnt_a !== t_gnt[k] || vld_a !== 1'b1 || pre_a !== 1'b0) begin
        n_err++;
        $display("FAIL rr[%0d] req=%h mode=%b gnt=%0d vld=%b pre=%b want gnt=%0d vld=1 pre=0",
                 k, t_req[k], t_mode[k], gnt_a, vld_a, pre_a, t_gnt[k]);
      end
    end
  endtask

  task automatic test_hold_timeout;
    logic [2:0] exp_gnt;
    logic       exp_pre;
    mode_b = 1'b1;
    req_b  = 8'h0A;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_gnt = ((k / 4) % 2 == 1) ? 3'd3 : 3'd1;
      exp_pre = (k == 4 || k == 8);
      n_vec++;
      if (gnt_b !== exp_gnt || pre_b !== exp_pre) begin
        n_err++;
        $display("FAIL hold[%0d] gnt=%0d pre=%b want gnt=%0d pre=%b", k, gnt_b, pre_b, exp_gnt, exp_pre);
      end
    end
  endtask

  task automatic test_hold_alone;
    req_b = 8'h10;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_vec++;
      if (gnt_b !== 3'd4 || pre_b !== 1'b0) begin
        n_err++;
        $display("FAIL alone[%0d] gnt=%0d pre=%b want gnt=4 pre=0", k, gnt_b, pre_b);
      end
    end
    req_b = 8'h14;
    tick();
    n_vec++;
    if (gnt_b !== 3'd2 || pre_b !== 1'b1) begin
      n_err++;
      $display("FAIL saturated_preempt gnt=%0d pre=%b want gnt=2 pre=1", gnt_b, pre_b);
    end
    req_b = 8'h04;
    tick();
    n_vec++;
    if (gnt_b !== 3'd2 || pre_b !== 1'b0) begin
      n_err++;
      $display("FAIL preempt_single_cycle gnt=%0d pre=%b want gnt=2 pre=0", gnt_b, pre_b);
    end
  endtask

  task automatic test_nonpow2;
    logic [4:0] t_req  [6] = '{5'h10, 5'h13, 5'h03, 5'h1E, 5'h18, 5'h00};
    logic       t_mode [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] t_gnt  [6] = '{3'd4, 3'd4, 3'd0, 3'd1, 3'd3, 3'd3};
    logic       t_vld  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      req_c  = t_req[k];
      mode_c = t_mode[k];
      tick();
      n_vec++;
      if (gnt_c !== t_gnt[k] || vld_c !== t_vld[k]) begin
        n_err++;
        $display("FAIL nm5[%0d] req=%h gnt=%0d vld=%b want gnt=%0d vld=%b",
                 k, t_req[k], gnt_c, vld_c, t_gnt[k], t_vld[k]);
      end
    end
  endtask

  task automatic test_back_to_back_reset;
    mode_a = 1'b0;
    req_a  = 8'h40;
    tick();
    n_vec++; if (gnt_a !== 3'd6) begin n_err++; $display("FAIL pre_reset_gnt got %0d want 6", gnt_a); end
    rst_a = 1'b1;
    tick();
    n_vec++; if (gnt_a !== 3'd0) begin n_err++; $display("FAIL mid_reset_gnt got %0d want 0", gnt_a); end
    n_vec++; if (oh_a !== 8'h01) begin n_err++; $display("FAIL mid_reset_oh got %h want 01", oh_a); end
    rst_a = 1'b0;
    tick();
    n_vec++;
    if (gnt_a !== 3'd6 || vld_a !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_gnt got %0d vld=%b want 6 vld=1", gnt_a, vld_a);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_hold_timeout();
    test_hold_alone();
    test_nonpow2();
    test_back_to_back_reset();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
